// File: rtl/if_id_skid_reg_pkg.sv
// Shared IF/ID definitions: widths, MIPS-I field positions, buffer state encoding
// and the beat/field payload types.
package if_id_skid_reg_pkg;

  localparam int unsigned INSTR_W   = 32;
  localparam int unsigned PC_W      = 32;

  localparam int unsigned OPCODE_W  = 6;
  localparam int unsigned REG_W     = 5;
  localparam int unsigned SHAMT_W   = 5;
  localparam int unsigned FUNCT_W   = 6;
  localparam int unsigned IMM_W     = 16;

  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 26;
  localparam int unsigned RS_MSB     = 25;
  localparam int unsigned RS_LSB     = 21;
  localparam int unsigned RT_MSB     = 20;
  localparam int unsigned RT_LSB     = 16;
  localparam int unsigned RD_MSB     = 15;
  localparam int unsigned RD_LSB     = 11;
  localparam int unsigned SHAMT_MSB  = 10;
  localparam int unsigned SHAMT_LSB  = 6;
  localparam int unsigned FUNCT_MSB  = 5;
  localparam int unsigned FUNCT_LSB  = 0;
  localparam int unsigned IMM_MSB    = 15;
  localparam int unsigned IMM_LSB    = 0;

  // sll $0,$0,0 -- the bubble presented to decode when the buffer is empty
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } beat_t;

  localparam beat_t BEAT_NOP = '{pc: '0, instr: NOP_INSTR};

  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic [REG_W-1:0]    rs;
    logic [REG_W-1:0]    rt;
    logic [REG_W-1:0]    rd;
    logic [SHAMT_W-1:0]  shamt;
    logic [FUNCT_W-1:0]  funct;
    logic [IMM_W-1:0]    imm;
  } fields_t;

  // Raw slicing of a MIPS-I word; no sign or zero extension of the immediate
  function automatic fields_t split_fields(input logic [INSTR_W-1:0] instr);
    fields_t f;
    f.opcode = instr[OPCODE_MSB:OPCODE_LSB];
    f.rs     = instr[RS_MSB:RS_LSB];
    f.rt     = instr[RT_MSB:RT_LSB];
    f.rd     = instr[RD_MSB:RD_LSB];
    f.shamt  = instr[SHAMT_MSB:SHAMT_LSB];
    f.funct  = instr[FUNCT_MSB:FUNCT_LSB];
    f.imm    = instr[IMM_MSB:IMM_LSB];
    return f;
  endfunction

endpackage

// File: rtl/if_id_skid_reg_if.sv
// IF/ID bundle: fetch-side valid/ready beat, flush, and decode-side head entry with fields.
interface if_id_skid_reg_if;
  import if_id_skid_reg_pkg::*;

  logic                if_valid;
  logic                if_ready;
  logic [INSTR_W-1:0]  if_instr;
  logic [PC_W-1:0]     if_pc;
  logic                flush;

  logic                id_valid;
  logic                id_ready;
  logic [INSTR_W-1:0]  id_instr;
  logic [PC_W-1:0]     id_pc;
  logic [OPCODE_W-1:0] id_opcode;
  logic [REG_W-1:0]    id_rs;
  logic [REG_W-1:0]    id_rt;
  logic [REG_W-1:0]    id_rd;
  logic [SHAMT_W-1:0]  id_shamt;
  logic [FUNCT_W-1:0]  id_funct;
  logic [IMM_W-1:0]    id_imm;

  // The buffer drives the ID side and if_ready
  modport master (
    input  if_valid, if_instr, if_pc, flush, id_ready,
    output if_ready, id_valid, id_instr, id_pc,
           id_opcode, id_rs, id_rt, id_rd, id_shamt, id_funct, id_imm
  );

  // Fetch and decode environment around the buffer
  modport slave (
    output if_valid, if_instr, if_pc, flush, id_ready,
    input  if_ready, id_valid, id_instr, id_pc,
           id_opcode, id_rs, id_rt, id_rd, id_shamt, id_funct, id_imm
  );

endinterface

// File: rtl/if_id_skid_reg_field_split.sv
// Combinational MIPS-I instruction field splitter, shared with later pipeline stages.
module if_id_skid_reg_field_split
  import if_id_skid_reg_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  output fields_t            fields_c
);

  assign fields_c = split_fields(instr);

endmodule

// File: rtl/if_id_skid_reg.sv
// IF/ID two-entry skid buffer: registers fetched beats, presents the head entry and
// its decoded fields to ID, with back-pressure and branch flush.
module if_id_skid_reg
  import if_id_skid_reg_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  if_id_skid_reg_if.master bus
);

  state_t  state;
  beat_t   main_q;
  beat_t   skid_q;
  logic    if_ready_q;
  logic    id_valid_q;

  beat_t   in_beat;
  logic    acc;
  logic    rel;
  fields_t head_fields;

  assign in_beat = '{pc: bus.if_pc, instr: bus.if_instr};
  assign acc     = bus.if_valid & if_ready_q;
  assign rel     = id_valid_q & bus.id_ready;

  // State, storage and handshake flags all update together; ready/valid are
  // registered copies of the next state so no input reaches them combinationally.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      state      <= ST_EMPTY;
      main_q     <= BEAT_NOP;
      skid_q     <= BEAT_NOP;
      if_ready_q <= 1'b1;
      id_valid_q <= 1'b0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (acc) begin
            main_q     <= in_beat;
            state      <= ST_ONE;
            id_valid_q <= 1'b1;
            if_ready_q <= 1'b1;
          end
        end
        ST_ONE: begin
          if (acc && !rel) begin
            skid_q     <= in_beat;
            state      <= ST_FULL;
            if_ready_q <= 1'b0;
          end else if (acc && rel) begin
            main_q     <= in_beat;
          end else if (rel) begin
            main_q     <= BEAT_NOP;
            state      <= ST_EMPTY;
            id_valid_q <= 1'b0;
          end
        end
        ST_FULL: begin
          if (rel) begin
            main_q     <= skid_q;
            skid_q     <= BEAT_NOP;
            state      <= ST_ONE;
            if_ready_q <= 1'b1;
          end
        end
        default: begin
          state      <= ST_EMPTY;
          main_q     <= BEAT_NOP;
          skid_q     <= BEAT_NOP;
          if_ready_q <= 1'b1;
          id_valid_q <= 1'b0;
        end
      endcase
    end
  end

  if_id_skid_reg_field_split u_field_split (
    .instr    (main_q.instr),
    .fields_c (head_fields)
  );

  assign bus.if_ready  = if_ready_q;
  assign bus.id_valid  = id_valid_q;
  assign bus.id_instr  = main_q.instr;
  assign bus.id_pc     = main_q.pc;
  assign bus.id_opcode = head_fields.opcode;
  assign bus.id_rs     = head_fields.rs;
  assign bus.id_rt     = head_fields.rt;
  assign bus.id_rd     = head_fields.rd;
  assign bus.id_shamt  = head_fields.shamt;
  assign bus.id_funct  = head_fields.funct;
  assign bus.id_imm    = head_fields.imm;

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Directed self-checking bench for the IF/ID skid buffer.
module tb_if_id_skid_reg;

  logic clk;
  logic rst;
  int   passed;
  int   total;

  if_id_skid_reg_if bus ();

  if_id_skid_reg dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Head entry and every field, with fields sliced from the expected word
  task automatic chk_head(input string tag, input logic v, input logic [31:0] ins,
                          input logic [31:0] pc);
    logic [31:0] w;
    w = ins;
    check({tag, ".valid"}, 32'(bus.id_valid), 32'(v));
    check({tag, ".instr"}, bus.id_instr, w);
    check({tag, ".pc"},    bus.id_pc, pc);
    check({tag, ".opcode"}, 32'(bus.id_opcode), 32'(w[31:26]));
    check({tag, ".rs"},     32'(bus.id_rs),     32'(w[25:21]));
    check({tag, ".rt"},     32'(bus.id_rt),     32'(w[20:16]));
    check({tag, ".rd"},     32'(bus.id_rd),     32'(w[15:11]));
    check({tag, ".shamt"},  32'(bus.id_shamt),  32'(w[10:6]));
    check({tag, ".funct"},  32'(bus.id_funct),  32'(w[5:0]));
    check({tag, ".imm"},    32'(bus.id_imm),    32'(w[15:0]));
  endtask

  task automatic offer(input logic v, input logic [31:0] ins, input logic [31:0] pc);
    bus.if_valid = v;
    bus.if_instr = ins;
    bus.if_pc    = pc;
  endtask

  initial begin
    passed       = 0;
    total        = 0;
    rst          = 1'b1;
    bus.flush    = 1'b0;
    bus.id_ready = 1'b0;
    offer(1'b0, 32'h0, 32'h0);

    // Reset
    tick();
    tick();
    chk_head("reset", 1'b0, 32'h0, 32'h0);
    check("reset.if_ready", 32'(bus.if_ready), 32'd1);
    rst = 1'b0;

    // Streaming, one beat per cycle
    bus.id_ready = 1'b1;
    offer(1'b1, 32'h012A_4020, 32'h100);
    tick();
    chk_head("stream0", 1'b1, 32'h012A_4020, 32'h100);
    check("stream0.rs", 32'(bus.id_rs), 32'd9);
    check("stream0.rt", 32'(bus.id_rt), 32'd10);
    check("stream0.rd", 32'(bus.id_rd), 32'd8);
    check("stream0.funct", 32'(bus.id_funct), 32'h20);
    offer(1'b1, 32'h8D09_0004, 32'h104);
    tick();
    chk_head("stream1", 1'b1, 32'h8D09_0004, 32'h104);
    check("stream1.opcode", 32'(bus.id_opcode), 32'h23);
    check("stream1.imm", 32'(bus.id_imm), 32'h0004);
    check("stream1.if_ready", 32'(bus.if_ready), 32'd1);
    offer(1'b1, 32'hAC0B_0008, 32'h108);
    tick();
    chk_head("stream2", 1'b1, 32'hAC0B_0008, 32'h108);
    offer(1'b1, 32'h3C01_1234, 32'h10C);
    tick();
    chk_head("stream3", 1'b1, 32'h3C01_1234, 32'h10C);
    offer(1'b0, 32'h0, 32'h0);
    tick();
    chk_head("stream_drain", 1'b0, 32'h0, 32'h0);

    // Back-pressure: A, B accepted, C held by fetch
    bus.id_ready = 1'b0;
    offer(1'b1, 32'h2108_0001, 32'h200);
    tick();
    chk_head("bp_a", 1'b1, 32'h2108_0001, 32'h200);
    check("bp_a.if_ready", 32'(bus.if_ready), 32'd1);
    offer(1'b1, 32'h0109_5022, 32'h204);
    tick();
    chk_head("bp_full", 1'b1, 32'h2108_0001, 32'h200);
    check("bp_full.if_ready", 32'(bus.if_ready), 32'd0);
    offer(1'b1, 32'h0800_0040, 32'h208);
    tick();
    chk_head("bp_hold1", 1'b1, 32'h2108_0001, 32'h200);
    check("bp_hold1.if_ready", 32'(bus.if_ready), 32'd0);
    tick();
    chk_head("bp_hold2", 1'b1, 32'h2108_0001, 32'h200);
    bus.id_ready = 1'b1;
    tick();
    chk_head("bp_b", 1'b1, 32'h0109_5022, 32'h204);
    check("bp_b.if_ready", 32'(bus.if_ready), 32'd1);
    tick();
    chk_head("bp_c", 1'b1, 32'h0800_0040, 32'h208);
    offer(1'b0, 32'h0, 32'h0);
    tick();
    chk_head("bp_drain", 1'b0, 32'h0, 32'h0);

    // Flush while FULL with a beat offered
    bus.id_ready = 1'b0;
    offer(1'b1, 32'h2109_0011, 32'h300);
    tick();
    offer(1'b1, 32'h2109_0022, 32'h304);
    tick();
    check("fl_full.if_ready", 32'(bus.if_ready), 32'd0);
    bus.flush = 1'b1;
    offer(1'b1, 32'h2109_0033, 32'h308);
    tick();
    chk_head("fl_full", 1'b0, 32'h0, 32'h0);
    check("fl_full.if_ready_after", 32'(bus.if_ready), 32'd1);
    bus.flush    = 1'b0;
    bus.id_ready = 1'b1;
    offer(1'b0, 32'h0, 32'h0);
    tick();
    chk_head("fl_full_after", 1'b0, 32'h0, 32'h0);

    // Flush in ONE drops a beat offered with if_ready=1
    offer(1'b1, 32'h2109_0044, 32'h30C);
    tick();
    chk_head("fl_one_pre", 1'b1, 32'h2109_0044, 32'h30C);
    bus.flush = 1'b1;
    offer(1'b1, 32'h2109_0055, 32'h310);
    tick();
    chk_head("fl_one", 1'b0, 32'h0, 32'h0);
    bus.flush = 1'b0;
    offer(1'b0, 32'h0, 32'h0);
    tick();
    chk_head("fl_one_after", 1'b0, 32'h0, 32'h0);
    check("fl_one_after.if_ready", 32'(bus.if_ready), 32'd1);

    // Simultaneous accept and release in ONE for 8 cycles
    offer(1'b1, 32'h2000_0000, 32'h400);
    tick();
    chk_head("sim_0", 1'b1, 32'h2000_0000, 32'h400);
    for (int i = 1; i <= 8; i++) begin
      offer(1'b1, 32'h2000_0000 + 32'(i), 32'h400 + 32'(4 * i));
      tick();
      chk_head($sformatf("sim_%0d", i), 1'b1, 32'h2000_0000 + 32'(i), 32'h400 + 32'(4 * i));
      check($sformatf("sim_%0d.if_ready", i), 32'(bus.if_ready), 32'd1);
    end
    offer(1'b0, 32'h0, 32'h0);
    tick();
    chk_head("sim_drain", 1'b0, 32'h0, 32'h0);

    // Reset while FULL and stalled
    bus.id_ready = 1'b0;
    offer(1'b1, 32'h2210_0001, 32'h500);
    tick();
    offer(1'b1, 32'h2210_0002, 32'h504);
    tick();
    check("rst_full.if_ready", 32'(bus.if_ready), 32'd0);
    rst = 1'b1;
    tick();
    chk_head("rst_full", 1'b0, 32'h0, 32'h0);
    check("rst_full.if_ready_after", 32'(bus.if_ready), 32'd1);
    rst = 1'b0;
    bus.id_ready = 1'b1;
    offer(1'b0, 32'h0, 32'h0);
    tick();
    chk_head("rst_full_after", 1'b0, 32'h0, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
